// File: rtl/cga_line_doubler.sv
// CGA 15 kHz -> 31 kHz line doubler: ping-pong line buffer, each captured line replayed twice.
// Optional CGA_LINE_DOUBLER_SCANLINE_EN dims the second replay by clearing intensity.
module cga_line_doubler #(
  parameter int DEPTH       = 1024,
  parameter int HSYNC_WIDTH = 96
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_reset,
  input  logic       pix_ce,
  input  logic       dbl_ce,
  input  logic [3:0] video,
  output logic [3:0] dbl_video,
  output logic       dbl_hsync,
  output logic       dbl_pass
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(HSYNC_WIDTH + 1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
  localparam logic [SW-1:0] SYNC_MAX = SW'(HSYNC_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } rd_state_t;

  logic [3:0]    mem [0:2*DEPTH-1];
  logic [3:0]    ram_q_r;
  logic          wr_bank_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_len_r;
  logic          synced_r;
  rd_state_t     state_r;
  logic [AW-1:0] rd_ptr_r;
  logic [SW-1:0] sync_cnt_r;
  logic          s1_ce_r;
  logic          s1_en_r;
  logic          s1_hsync_r;
  logic          s1_pass_r;

  logic          we_s;
  logic [AW:0]   wr_addr_s;
  rd_state_t     eff_state_s;
  logic [AW-1:0] eff_ptr_s;
  logic [SW-1:0] eff_sync_s;
  logic [PW-1:0] eff_len_s;
  logic          rd_bank_s;
  logic          active_s;
  logic          last_s;
  logic [AW:0]   rd_addr_s;
  rd_state_t     nxt_state_s;
  logic [AW-1:0] nxt_ptr_s;
  logic [SW-1:0] nxt_sync_s;
  logic [3:0]    vid_s;

  // Write port: a coincident line_reset redirects the pixel to address 0 of the new bank
  always_comb begin
    we_s      = 1'b0;
    wr_addr_s = {wr_bank_r, wr_ptr_r[AW-1:0]};
    if (line_reset) begin
      we_s      = pix_ce;
      wr_addr_s = {~wr_bank_r, {AW{1'b0}}};
    end else begin
      we_s      = pix_ce && (wr_ptr_r != PTR_FULL);
    end
  end

  // Read context as seen this cycle; a line_reset restarts it before the read is issued
  always_comb begin
    eff_state_s = state_r;
    eff_ptr_s   = rd_ptr_r;
    eff_sync_s  = sync_cnt_r;
    eff_len_s   = rd_len_r;
    rd_bank_s   = ~wr_bank_r;
    if (line_reset) begin
      eff_state_s = PASS0;
      eff_ptr_s   = {AW{1'b0}};
      eff_sync_s  = {SW{1'b0}};
      eff_len_s   = synced_r ? wr_ptr_r : {PW{1'b0}};
      rd_bank_s   = wr_bank_r;
    end else begin
      rd_bank_s   = ~wr_bank_r;
    end
    active_s  = (eff_state_s != IDLE) && (eff_len_s != {PW{1'b0}});
    last_s    = ({1'b0, eff_ptr_s} == (eff_len_s - PW'(1)));
    rd_addr_s = {rd_bank_s, eff_ptr_s};
  end

  // Replay sequencing: pointer, sync counter and pass transitions per dbl_ce tick
  always_comb begin
    nxt_state_s = eff_state_s;
    nxt_ptr_s   = eff_ptr_s;
    nxt_sync_s  = eff_sync_s;
    if (eff_len_s == {PW{1'b0}}) begin
      nxt_state_s = IDLE;
    end else if (dbl_ce && active_s) begin
      nxt_ptr_s  = eff_ptr_s + AW'(1);
      nxt_sync_s = (eff_sync_s == SYNC_MAX) ? eff_sync_s : eff_sync_s + SW'(1);
      if (last_s) begin
        case (eff_state_s)
          PASS0: begin
            nxt_state_s = PASS1;
            nxt_ptr_s   = {AW{1'b0}};
            nxt_sync_s  = {SW{1'b0}};
          end
          PASS1:   nxt_state_s = IDLE;
          default: nxt_state_s = IDLE;
        endcase
      end else begin
        nxt_state_s = eff_state_s;
      end
    end else begin
      nxt_state_s = eff_state_s;
    end
  end

  // Line buffer RAM: synchronous write, synchronous read on dbl_ce
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wr_addr_s] <= video;
    end
    if (dbl_ce) begin
      ram_q_r <= mem[rd_addr_s];
    end
  end

  // Write-side bookkeeping: bank swap, pixel pointer, captured line length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_r <= 1'b0;
      wr_ptr_r  <= {PW{1'b0}};
      rd_len_r  <= {PW{1'b0}};
      synced_r  <= 1'b0;
    end else if (line_reset) begin
      wr_bank_r <= ~wr_bank_r;
      wr_ptr_r  <= pix_ce ? PW'(1) : {PW{1'b0}};
      rd_len_r  <= eff_len_s;
      synced_r  <= 1'b1;
    end else if (we_s) begin
      wr_ptr_r  <= wr_ptr_r + PW'(1);
    end
  end

  // Read FSM state and the first pipeline stage alongside the RAM read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      rd_ptr_r   <= {AW{1'b0}};
      sync_cnt_r <= {SW{1'b0}};
      s1_ce_r    <= 1'b0;
      s1_en_r    <= 1'b0;
      s1_hsync_r <= 1'b0;
      s1_pass_r  <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      rd_ptr_r   <= nxt_ptr_s;
      sync_cnt_r <= nxt_sync_s;
      s1_ce_r    <= dbl_ce;
      if (dbl_ce) begin
        s1_en_r    <= active_s;
        s1_hsync_r <= active_s && (eff_sync_s < SYNC_MAX);
        s1_pass_r  <= active_s && (eff_state_s == PASS1);
      end
    end
  end

  // Scanline dimming of the second replay when enabled
  always_comb begin
`ifdef CGA_LINE_DOUBLER_SCANLINE_EN
    vid_s = s1_pass_r ? {1'b0, ram_q_r[2:0]} : ram_q_r;
`else
    vid_s = ram_q_r;
`endif
  end

  // Output register, loaded one cycle after each dbl_ce tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbl_video <= 4'h0;
      dbl_hsync <= 1'b0;
      dbl_pass  <= 1'b0;
    end else if (s1_ce_r) begin
      dbl_video <= s1_en_r ? vid_s : 4'h0;
      dbl_hsync <= s1_hsync_r;
      dbl_pass  <= s1_pass_r;
    end
  end

endmodule
